// File: rtl/time_adjust_counter.sv
// Time-of-day register bank (hour/minute/second). In run mode it advances from an
// internal 1 Hz prescaler; in adjust mode the prescaler freezes and each debounced
// press of the active-low adjust key increments the selected field, with no carry.
module time_adjust_counter #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] option,
  input  logic       adj_mode,
  input  logic       adj_key,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       tick_1hz
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DbMax    = DW'(DEBOUNCE_CYCLES - 1);

  // Key path state
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_del_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;

  // Time path state
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;

  // Wrapping increments at field width
  logic [4:0] hour_inc;
  logic [5:0] min_inc, sec_inc;

  assign hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
  assign min_inc  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
  assign sec_inc  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;

  // Debouncer: count while the synchronised level differs from the accepted level
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DbMax) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    // Only the falling edge of the accepted level (key pushed) makes a press
    press_d = stable_del_q & ~stable_q;
  end

  // Prescaler and time fields: run-mode advance with carry, adjust-mode increment without
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (adj_mode) begin
      // Frozen prescaler; adj_mode also wins over a tick due on this edge
      presc_d = '0;
      if (press_q) begin
        case (option)
          2'd0:    sec_d  = sec_inc;
          2'd1:    min_d  = min_inc;
          2'd2:    hour_d = hour_inc;
          default: ;
        endcase
      end
    end else if (presc_q == PrescMax) begin
      presc_d = '0;
      tick_d  = 1'b1;
      sec_d   = sec_inc;
      if (sec_q == 6'd59) begin
        min_d = min_inc;
        if (min_q == 6'd59) begin
          hour_d = hour_inc;
        end
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Key synchroniser, debouncer and press pulse registers; reset state is "released"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_del_q <= 1'b1;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= adj_key;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_del_q <= stable_q;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
    end
  end

  // Prescaler, tick and time-of-day registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign hour     = hour_q;
  assign minute   = min_q;
  assign second   = sec_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_time_adjust_counter.sv
// Directed bench for time_adjust_counter with a short prescaler and debounce window.
module tb_time_adjust_counter;

  localparam int unsigned CF = 10;
  localparam int unsigned DB = 8;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [1:0] option   = 2'd0;
  logic       adj_mode = 1'b0;
  logic       adj_key  = 1'b1;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       tick_1hz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] opt;
    int         n;
    int         h;
    int         m;
    int         s;
  } adj_vec_t;

  adj_vec_t vecs [10];

  always #5 clk = ~clk;

  time_adjust_counter #(
    .CLK_FREQ        (CF),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .option   (option),
    .adj_mode (adj_mode),
    .adj_key  (adj_key),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .tick_1hz (tick_1hz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, ".hour"}, 32'(hour), 32'(h));
    check({name, ".minute"}, 32'(minute), 32'(m));
    check({name, ".second"}, 32'(second), 32'(s));
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear without a clock edge
  task automatic pulse_reset(input string name);
    #2 rst = 1'b1;
    #1;
    check_time(name, 0, 0, 0);
    check({name, ".tick"}, 32'(tick_1hz), 32'd0);
    #3 rst = 1'b0;
  endtask

  // One clean push and release, each held long enough to be accepted
  task automatic do_press();
    adj_key = 1'b0;
    repeat (DB + 6) step();
    adj_key = 1'b1;
    repeat (DB + 6) step();
  endtask

  initial begin
    vecs[0] = '{2'd2, 23, 23, 1, 0};
    vecs[1] = '{2'd1, 58, 23, 59, 0};
    vecs[2] = '{2'd1, 1, 23, 0, 0};
    vecs[3] = '{2'd1, 59, 23, 59, 0};
    vecs[4] = '{2'd0, 59, 23, 59, 59};
    vecs[5] = '{2'd0, 1, 23, 59, 0};
    vecs[6] = '{2'd3, 2, 23, 59, 0};
    vecs[7] = '{2'd0, 58, 23, 59, 58};
    vecs[8] = '{2'd2, 1, 0, 59, 58};
    vecs[9] = '{2'd2, 23, 23, 59, 58};

    // Reset held from time zero, then free run for three seconds
    #3;
    check_time("reset_hold", 0, 0, 0);
    check("reset_hold.tick", 32'(tick_1hz), 32'd0);
    #4 rst = 1'b0;
    for (int i = 1; i <= 3 * CF; i++) begin
      step();
      check($sformatf("run_tick[%0d]", i), 32'(tick_1hz), 32'((i % CF) == 0));
    end
    check_time("run_3s", 0, 0, 3);

    // Adjust latency: key low before edge N updates the field on edge N+DB+3
    adj_mode = 1'b1;
    option   = 2'd1;
    pulse_reset("reset_async");
    adj_key = 1'b0;
    for (int k = 1; k <= DB + 4; k++) begin
      step();
      check($sformatf("latency_min[%0d]", k), 32'(minute), 32'(k == DB + 4));
    end
    adj_key = 1'b1;
    repeat (DB + 6) step();
    check_time("latency_done", 0, 1, 0);

    // Table of adjust presses, ending at 23:59:58
    for (int v = 0; v < 10; v++) begin
      option = vecs[v].opt;
      for (int p = 0; p < vecs[v].n; p++) do_press();
      check_time($sformatf("adj_vec[%0d]", v), vecs[v].h, vecs[v].m, vecs[v].s);
    end

    // Rollover in run mode; prescaler restarts from 0 on leaving adjust mode
    adj_mode = 1'b0;
    for (int i = 1; i <= 2 * CF; i++) begin
      step();
      check($sformatf("roll_tick[%0d]", i), 32'(tick_1hz), 32'((i % CF) == 0));
      if (i == CF) check_time("roll_1", 23, 59, 59);
    end
    check_time("roll_2", 0, 0, 0);

    // Adjust mode freezes time and suppresses ticks
    adj_mode = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      check($sformatf("frozen_tick[%0d]", i), 32'(tick_1hz), 32'd0);
    end
    check_time("frozen", 0, 0, 0);
    adj_mode = 1'b0;
    for (int i = 1; i <= CF; i++) begin
      step();
      check($sformatf("resume_tick[%0d]", i), 32'(tick_1hz), 32'(i == CF));
    end
    check_time("resume", 0, 0, 1);

    // Run-mode press is ignored; exactly 5 ticks over 50 cycles
    option = 2'd0;
    adj_key = 1'b0;
    repeat (20) step();
    adj_key = 1'b1;
    repeat (30) step();
    check_time("run_press", 0, 0, 6);

    // Short glitches never get accepted
    adj_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      adj_key = 1'b0;
      repeat (5) step();
      adj_key = 1'b1;
      repeat (10) step();
    end
    check_time("glitch", 0, 0, 6);

    // Press bounce then steady low: one increment
    adj_key = 1'b0; repeat (2) step();
    adj_key = 1'b1; repeat (1) step();
    adj_key = 1'b0; repeat (1) step();
    adj_key = 1'b1; repeat (2) step();
    adj_key = 1'b0; repeat (20) step();
    check_time("bounce_press", 0, 0, 7);

    // Release bounce: nothing
    adj_key = 1'b1; repeat (1) step();
    adj_key = 1'b0; repeat (2) step();
    adj_key = 1'b1; repeat (2) step();
    adj_key = 1'b0; repeat (1) step();
    adj_key = 1'b1; repeat (20) step();
    check_time("bounce_release", 0, 0, 7);

    // Reset mid-prescaler and mid-debounce, with the key held low across release
    adj_mode = 1'b0;
    repeat (4) step();
    adj_key = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check_time("mid_reset", 0, 0, 0);
    check("mid_reset.tick", 32'(tick_1hz), 32'd0);
    adj_mode = 1'b1;
    option   = 2'd0;
    #3 rst = 1'b0;
    for (int k = 1; k <= DB + 4; k++) begin
      step();
      check($sformatf("held_key_sec[%0d]", k), 32'(second), 32'(k == DB + 4));
    end
    repeat (20) step();
    check_time("held_key_once", 0, 0, 1);
    adj_key = 1'b1;
    repeat (DB + 6) step();
    check_time("held_key_release", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
